data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 11 +
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/dmem_array.sv | 24 ++
 rtl/data_mem_responder.sv | 85 ++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, geometry constants and initial-image helper for the data memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DMEM_DEPTH_DEFAULT = 40;
  localparam int DMEM_IDX_LSB = 2;
  localparam int DMEM_IDX_MSB = 7;
  localparam int DMEM_IDX_W = DMEM_IDX_MSB - DMEM_IDX_LSB + 1;
  function automatic logic [31:0] dmem_init(int i);
    return i <= 20 ? 32'(i * (20 - i)) : 32'd0;
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bus between an initiator (master) and the responder (slave).
interface data_mem_responder_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0] req_wstrb;
  logic resp_valid;
  logic resp_ready;
  logic [31:0] resp_rdata;
  logic resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with a synchronous byte-enabled write port and a combinational read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DMEM_IDX_W-1:0] idx,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata
);
  logic [31:0] words [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] word = dmem_init(g);
    always_ff @(posedge clk)
      if (we && 32'(idx) == g)
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] <= wdata[8*b +: 8];
    assign words[g] = word;
  end
  assign rdata = 32'(idx) < DEPTH ? words[idx] : '0;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory slave with an IDLE/WAIT/RESP handshake FSM.
// Build option: define DMEM_WSTRB_EN to honour req_wstrb byte lanes on stores.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);
  state_t state;
  logic [3:0] cnt;
  logic we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic idle, accept, enter_resp, cur_we, cur_err, wr_en;
  logic [31:0] cur_addr, cur_wdata, rd_word, lane_mask, merged;
  logic [3:0] be;
  logic [DMEM_IDX_W-1:0] idx;
  assign idle = state == IDLE;
  assign accept = idle && bus.req_valid && !reset;
  assign enter_resp = idle ? accept && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd1;
  // with no wait states the request is consumed on the same edge that accepts it
  assign cur_we = idle ? bus.req_we : we_q;
  assign cur_addr = idle ? bus.req_addr : addr_q;
  assign cur_wdata = idle ? bus.req_wdata : wdata_q;
  assign idx = cur_addr[DMEM_IDX_MSB:DMEM_IDX_LSB];
  assign cur_err = cur_addr[DMEM_IDX_LSB-1:0] != '0 || cur_addr[31:DMEM_IDX_MSB+1] != '0 || 32'(idx) >= DEPTH;
`ifdef DMEM_WSTRB_EN
  logic [3:0] wstrb_q;
  always_ff @(posedge clk)
    if (accept) wstrb_q <= bus.req_wstrb;
  assign be = idle ? bus.req_wstrb : wstrb_q;
`else
  assign be = 4'hf;
`endif
  assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged = cur_we ? (rd_word & ~lane_mask) | (cur_wdata & lane_mask) : rd_word;
  assign wr_en = enter_resp && cur_we && !cur_err;
  always_ff @(posedge clk)
    if (accept) begin
      we_q <= bus.req_we;
      addr_q <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          state <= WAIT_CYCLES == 0 ? RESP : WAIT;
          cnt <= 4'(WAIT_CYCLES);
        end
        WAIT: begin
          state <= cnt == 4'd1 ? RESP : WAIT;
          cnt <= cnt - 4'd1;
        end
        RESP: if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        rdata_q <= cur_err ? '0 : merged;
        err_q <= cur_err;
      end
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(wr_en),
    .idx(idx),
    .wdata(merged),
    .be(be),
    .rdata(rd_word)
  );
  assign bus.req_ready = idle;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
  assign busy = !idle;
endmodule
